// File: rtl/module_secded_decoder_pkg.sv
// Shared extended-Hamming helpers: parity width, data bit placement, encoder.
// The encoder is not used by the decoder datapath; it serves stimulus generation.
package pkg_hamming;

    localparam int unsigned MAX_N = 64;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SEC  = 2'd1,
        ST_DED  = 2'd2
    } secded_status_t;

    // Smallest r with 2**r >= data_w + r + 1.
    function automatic int unsigned par_width(input int unsigned data_w);
        for (int unsigned r = 1; r < 8; r++) begin
            if ((32'd1 << r) >= data_w + r + 1) return r;
        end
        return 8;
    endfunction

    // Data bits fill the non-power-of-two positions in ascending order from 3.
    function automatic int unsigned data_pos(input int unsigned i);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned p = 3; p < MAX_N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == i) return p;
                cnt++;
            end
        end
        return 0;
    endfunction

    function automatic logic [MAX_N-1:0] encode(input logic [MAX_N-1:0] data,
                                                input int unsigned data_w);
        logic [MAX_N-1:0] w;
        int unsigned      pw;
        int unsigned      n;
        logic             p;
        pw = par_width(data_w);
        n  = data_w + pw + 1;
        w  = '0;
        for (int unsigned i = 0; i < data_w; i++) w[data_pos(i)] = data[i];
        for (int unsigned j = 0; j < pw; j++) begin
            p = 1'b0;
            for (int unsigned k = 1; k < n; k++) begin
                if (k[j]) p ^= w[k];
            end
            w[32'd1 << j] = p;
        end
        w[0] = ^w;
        return w;
    endfunction

endpackage

// File: rtl/module_secded_decoder_syndrome.sv
// Combinational Hamming syndrome and overall parity of an extended codeword.
module module_secded_syndrome
    import pkg_hamming::*;
#(
    parameter  int unsigned DATA_W = 4,
    localparam int unsigned PAR_W  = par_width(DATA_W),
    localparam int unsigned N      = DATA_W + PAR_W + 1
) (
    input  logic [N-1:0]     word_i,
    output logic [PAR_W-1:0] syndrome_o,
    output logic             parity_o
);

    always_comb begin
        syndrome_o = '0;
        for (int unsigned j = 0; j < PAR_W; j++) begin
            for (int unsigned k = 1; k < N; k++) begin
                if (k[j]) syndrome_o[j] = syndrome_o[j] ^ word_i[k];
            end
        end
        parity_o = ^word_i;
    end

endmodule

// File: rtl/module_secded_decoder.sv
// Two-stage streaming SEC-DED decoder with valid/ready handshake and
// saturating SEC/DED statistics counted on output delivery.
module module_secded_decoder
    import pkg_hamming::*;
#(
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned PAR_W  = par_width(DATA_W),
    localparam int unsigned N      = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [N-1:0]      out_word,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic [1:0]        out_status,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_sec,
    output logic [CNT_W-1:0]  cnt_ded
);

    logic                s1_valid_q;
    logic [N-1:0]        s1_word_q;
    logic [PAR_W-1:0]    s1_syn_q;
    logic                s1_par_q;

    logic                out_valid_q;
    logic [N-1:0]        out_word_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [PAR_W-1:0]    out_syn_q;
    secded_status_t      out_status_q;
    logic [CNT_W-1:0]    cnt_sec_q, cnt_sec_d;
    logic [CNT_W-1:0]    cnt_ded_q, cnt_ded_d;

    logic [PAR_W-1:0]    syn_d;
    logic                par_d;
    logic [N-1:0]        flip;
    logic [N-1:0]        word_d;
    logic [DATA_W-1:0]   data_d;
    secded_status_t      status_d;
    logic                s1_adv, s2_adv;

    module_secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .word_i     (in_word),
        .syndrome_o (syn_d),
        .parity_o   (par_d)
    );

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // A syndrome beyond N-1 points outside the word and can only come from a multi-bit error.
    always_comb begin
        flip     = '0;
        status_d = ST_NONE;
        if (s1_syn_q == '0) begin
            if (s1_par_q) begin
                status_d = ST_SEC;
                flip[0]  = 1'b1;
            end
        end else if (!s1_par_q || (32'(s1_syn_q) > N - 1)) begin
            status_d = ST_DED;
        end else begin
            status_d = ST_SEC;
            for (int unsigned k = 0; k < N; k++) begin
                if (32'(s1_syn_q) == k) flip[k] = 1'b1;
            end
        end
        word_d = s1_word_q ^ flip;
        data_d = '0;
        for (int unsigned i = 0; i < DATA_W; i++) data_d[i] = word_d[data_pos(i)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_word_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            out_status_q <= ST_NONE;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_word_q <= in_word;
                    s1_syn_q  <= syn_d;
                    s1_par_q  <= par_d;
                end
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_word_q   <= word_d;
                    out_data_q   <= data_d;
                    out_syn_q    <= s1_syn_q;
                    out_status_q <= status_d;
                end
            end
        end
    end

    always_comb begin
        cnt_sec_d = cnt_sec_q;
        cnt_ded_d = cnt_ded_q;
        if (clr_cnt) begin
            cnt_sec_d = '0;
            cnt_ded_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_status_q == ST_SEC && cnt_sec_q != '1) cnt_sec_d = cnt_sec_q + 1'b1;
            if (out_status_q == ST_DED && cnt_ded_q != '1) cnt_ded_d = cnt_ded_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_sec_q <= '0;
            cnt_ded_q <= '0;
        end else begin
            cnt_sec_q <= cnt_sec_d;
            cnt_ded_q <= cnt_ded_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_word     = out_word_q;
    assign out_syndrome = out_syn_q;
    assign out_status   = out_status_q;
    assign cnt_sec      = cnt_sec_q;
    assign cnt_ded      = cnt_ded_q;

endmodule

// File: tb/tb_module_secded_decoder.sv
// Self-checking bench: directed vectors, randomized stalled stream with scoreboard,
// counter saturation/clear, reset flush, and wide-configuration error sweeps.
module tb_module_secded_decoder;
    import pkg_hamming::*;

    typedef struct {
        logic [63:0] word;
        logic [63:0] cword;
        logic [63:0] data;
        logic [7:0]  syn;
        logic [1:0]  st;
    } exp_t;

    logic clk, rst;
    int unsigned checks, failures;

    // DATA_W=4 instances A (CNT_W=16) and B (CNT_W=2) share the input stream.
    logic       in_valid, out_ready, clr_cnt;
    logic [7:0] in_word;
    logic       in_ready, out_valid;
    logic [3:0] out_data;
    logic [7:0] out_word;
    logic [2:0] out_syndrome;
    logic [1:0] out_status;
    logic [15:0] cnt_sec, cnt_ded;
    logic       b_in_ready, b_out_valid;
    logic [3:0] b_out_data;
    logic [7:0] b_out_word;
    logic [2:0] b_out_syndrome;
    logic [1:0] b_out_status;
    logic [1:0] b_cnt_sec, b_cnt_ded;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_clr;
    logic [15:0] c_in_word, c_out_word;
    logic [10:0] c_out_data;
    logic [3:0]  c_out_syndrome;
    logic [1:0]  c_out_status;
    logic [15:0] c_cnt_sec, c_cnt_ded;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_clr;
    logic [31:0] d_in_word, d_out_word;
    logic [25:0] d_out_data;
    logic [4:0]  d_out_syndrome;
    logic [1:0]  d_out_status;
    logic [15:0] d_cnt_sec, d_cnt_ded;

    module_secded_decoder #(.DATA_W(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_word(out_word),
        .out_syndrome(out_syndrome), .out_status(out_status), .clr_cnt(clr_cnt),
        .cnt_sec(cnt_sec), .cnt_ded(cnt_ded));

    module_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_word(in_word),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_word(b_out_word),
        .out_syndrome(b_out_syndrome), .out_status(b_out_status), .clr_cnt(clr_cnt),
        .cnt_sec(b_cnt_sec), .cnt_ded(b_cnt_ded));

    module_secded_decoder #(.DATA_W(11)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_word(c_in_word),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_word(c_out_word),
        .out_syndrome(c_out_syndrome), .out_status(c_out_status), .clr_cnt(c_clr),
        .cnt_sec(c_cnt_sec), .cnt_ded(c_cnt_ded));

    module_secded_decoder #(.DATA_W(26)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_word(d_in_word),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .out_word(d_out_word),
        .out_syndrome(d_out_syndrome), .out_status(d_out_status), .clr_cnt(d_clr),
        .cnt_sec(d_cnt_sec), .cnt_ded(d_cnt_ded));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    exp_t        idle;
    int unsigned sec_a, ded_a, sec_b, ded_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected decode derived from the injected errors, not from decoding the word.
    function automatic exp_t make_vec(input int unsigned dw, input logic [63:0] data,
                                      input int unsigned nf, input int unsigned a,
                                      input int unsigned b);
        exp_t e;
        e.data  = data;
        e.word  = encode(data, dw);
        e.cword = e.word;
        e.syn   = 8'd0;
        e.st    = 2'd0;
        if (nf >= 1) e.word[a] = ~e.word[a];
        if (nf == 1) begin
            e.st  = 2'd1;
            e.syn = 8'(a);
        end else if (nf == 2) begin
            e.word[b] = ~e.word[b];
            e.st      = 2'd2;
            e.syn     = 8'(a ^ b);
            e.cword   = e.word;
            for (int unsigned i = 0; i < dw; i++) begin
                if (data_pos(i) == a || data_pos(i) == b) e.data[i] = ~e.data[i];
            end
        end
        return e;
    endfunction

    task automatic tick(input logic v, input exp_t e, input logic ordy, input logic clr);
        logic        ihs, ohs, hold;
        logic [63:0] snap;
        exp_t        x;
        in_valid  = v;
        in_word   = e.word[7:0];
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        ihs  = in_valid && in_ready;
        ohs  = out_valid && out_ready;
        hold = out_valid && !out_ready;
        snap = {47'd0, out_data, out_word, out_syndrome, out_status};
        if (ohs) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                x = q.pop_front();
                chk("out_data", 64'(out_data), x.data);
                chk("out_word", 64'(out_word), x.cword);
                chk("out_syndrome", 64'(out_syndrome), 64'(x.syn));
                chk("out_status", 64'(out_status), 64'(x.st));
                if (x.st == 2'd1) begin
                    if (sec_a < 65535) sec_a++;
                    if (sec_b < 3) sec_b++;
                end
                if (x.st == 2'd2) begin
                    if (ded_a < 65535) ded_a++;
                    if (ded_b < 3) ded_b++;
                end
            end
        end
        if (clr) begin
            sec_a = 0; ded_a = 0; sec_b = 0; ded_b = 0;
        end
        if (ihs) q.push_back(e);
        @(negedge clk);
        if (hold) chk("hold_stable", {47'd0, out_data, out_word, out_syndrome, out_status}, snap);
        chk("cnt_sec", 64'(cnt_sec), 64'(sec_a));
        chk("cnt_ded", 64'(cnt_ded), 64'(ded_a));
        chk("b_cnt_sec", 64'(b_cnt_sec), 64'(sec_b));
        chk("b_cnt_ded", 64'(b_cnt_ded), 64'(ded_b));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1'b0, idle, 1'b1, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic run_wide(input int unsigned dw, input exp_t e);
        logic        ov;
        logic [63:0] od, ow;
        logic [7:0]  os;
        logic [1:0]  st;
        if (dw == 11) begin
            c_in_valid = 1'b1; c_in_word = e.word[15:0];
        end else begin
            d_in_valid = 1'b1; d_in_word = e.word[31:0];
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        d_in_valid = 1'b0;
        @(negedge clk);
        if (dw == 11) begin
            ov = c_out_valid; od = 64'(c_out_data); ow = 64'(c_out_word);
            os = 8'(c_out_syndrome); st = c_out_status;
        end else begin
            ov = d_out_valid; od = 64'(d_out_data); ow = 64'(d_out_word);
            os = 8'(d_out_syndrome); st = d_out_status;
        end
        chk($sformatf("w%0d_valid", dw), 64'(ov), 64'd1);
        chk($sformatf("w%0d_data", dw), od, e.data);
        chk($sformatf("w%0d_word", dw), ow, e.cword);
        chk($sformatf("w%0d_syn", dw), 64'(os), 64'(e.syn));
        chk($sformatf("w%0d_status", dw), 64'(st), 64'(e.st));
    endtask

    initial begin
        exp_t        e;
        int unsigned a, b, n;
        checks = 0; failures = 0;
        sec_a = 0; ded_a = 0; sec_b = 0; ded_b = 0;
        idle = '{default: '0};
        rst = 1'b1;
        in_valid = 1'b0; in_word = '0; out_ready = 1'b0; clr_cnt = 1'b0;
        c_in_valid = 1'b0; c_in_word = '0; c_out_ready = 1'b1; c_clr = 1'b0;
        d_in_valid = 1'b0; d_in_word = '0; d_out_ready = 1'b1; d_clr = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", {47'd0, out_data, out_word, out_syndrome, out_status}, 64'd0);
        chk("rst_cnt", {32'd0, cnt_sec, cnt_ded}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean word and latency
        tick(1'b1, '{word: 64'hAA, cword: 64'hAA, data: 64'hB, syn: 8'd0, st: 2'd0}, 1'b1, 1'b0);
        chk("latency_1cyc", 64'(out_valid), 64'd0);
        tick(1'b0, idle, 1'b1, 1'b0);
        chk("latency_2cyc", 64'(out_valid), 64'd1);
        drain();

        // Single errors: data bit 5 and overall parity bit
        tick(1'b1, '{word: 64'h8A, cword: 64'hAA, data: 64'hB, syn: 8'd5, st: 2'd1}, 1'b1, 1'b0);
        tick(1'b1, '{word: 64'hAB, cword: 64'hAA, data: 64'hB, syn: 8'd0, st: 2'd1}, 1'b1, 1'b0);
        drain();

        // Double error: raw passthrough
        tick(1'b1, '{word: 64'h82, cword: 64'h82, data: 64'h8, syn: 8'd6, st: 2'd2}, 1'b1, 1'b0);
        drain();
        chk("cnt_sec_after3", 64'(cnt_sec), 64'd2);
        chk("cnt_ded_after3", 64'(cnt_ded), 64'd1);

        // Random stream with random backpressure
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(7);
            b = (a + 1 + $urandom_range(6)) % 8;
            e = make_vec(4, 64'($urandom_range(15)), $urandom_range(2), a, b);
            tick(1'($urandom_range(1)), e, 1'($urandom_range(1)), 1'b0);
        end
        drain();

        // Saturation on the CNT_W=2 instance, then clear racing a SEC delivery
        tick(1'b0, idle, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            e = make_vec(4, 64'($urandom_range(15)), 1, $urandom_range(7), 0);
            tick(1'b1, e, 1'b1, 1'b0);
        end
        drain();
        chk("b_sat", 64'(b_cnt_sec), 64'd3);
        chk("a_nosat", 64'(cnt_sec), 64'd5);
        tick(1'b1, make_vec(4, 64'd9, 1, 6, 0), 1'b0, 1'b0);
        tick(1'b0, idle, 1'b0, 1'b0);
        chk("clr_setup_valid", 64'(out_valid), 64'd1);
        tick(1'b0, idle, 1'b1, 1'b1);
        chk("clr_beats_inc", 64'(b_cnt_sec), 64'd0);

        // Reset with words in flight
        tick(1'b1, make_vec(4, 64'd3, 1, 2, 0), 1'b1, 1'b0);
        drain();
        tick(1'b1, make_vec(4, 64'd5, 0, 0, 0), 1'b0, 1'b0);
        tick(1'b1, make_vec(4, 64'd6, 2, 1, 7), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_flush_valid", 64'(out_valid), 64'd0);
        chk("rst_flush_cnt", {32'd0, cnt_sec, cnt_ded}, 64'd0);
        chk("rst_flush_ready", 64'(in_ready), 64'd1);
        q.delete();
        sec_a = 0; ded_a = 0; sec_b = 0; ded_b = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b0, idle, 1'b1, 1'b0);
        chk("no_stale", 64'(out_valid), 64'd0);

        // Wide sweeps: every single flip, random double flips, one clean word
        for (int unsigned w = 0; w < 2; w++) begin
            int unsigned dw;
            logic [63:0] dmask;
            dw    = (w == 0) ? 11 : 26;
            n     = dw + par_width(dw) + 1;
            dmask = (64'd1 << dw) - 64'd1;
            run_wide(dw, make_vec(dw, 64'($urandom) & dmask, 0, 0, 0));
            for (int unsigned k = 0; k < n; k++) run_wide(dw, make_vec(dw, 64'($urandom) & dmask, 1, k, 0));
            for (int i = 0; i < 10; i++) begin
                a = $urandom_range(n - 1);
                b = (a + 1 + $urandom_range(n - 2)) % n;
                run_wide(dw, make_vec(dw, 64'($urandom) & dmask, 2, a, b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
